// File: rtl/adsr_pkg.sv
// Shared constants for the ADSR envelope block: level width, attack peak, phase encoding.
package adsr_pkg;
    localparam int            W         = 20;
    localparam logic [W-1:0]  LEVEL_MAX = '1;

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_ATTACK  = 3'd1,
        PH_DECAY   = 3'd2,
        PH_SUSTAIN = 3'd3,
        PH_RELEASE = 3'd4
    } phase_e;
endpackage

// File: rtl/adsr_envelope_core_if.sv
// Control/status bundle between a voice controller (master) and the envelope core (slave).
interface adsr_envelope_core_if;
    import adsr_pkg::*;

    logic         tick;
    logic         gate;
    logic [W-1:0] attack_step;
    logic [W-1:0] decay_step;
    logic [W-1:0] sustain_level;
    logic [W-1:0] release_step;
    logic [W-1:0] level;
    logic [2:0]   phase;
    logic         active;

    modport master (
        output tick, gate, attack_step, decay_step, sustain_level, release_step,
        input  level, phase, active
    );

    modport slave (
        input  tick, gate, attack_step, decay_step, sustain_level, release_step,
        output level, phase, active
    );
endinterface

// File: rtl/adsr_envelope_core_env_sat_step.sv
// Saturating step toward a target: adds (dir=0) or subtracts (dir=1) step from level,
// landing exactly on target once it would be reached or passed. step==0 means "jump".
module env_sat_step
    import adsr_pkg::*;
(
    input  logic [W-1:0] i_level,
    input  logic [W-1:0] i_step,
    input  logic [W-1:0] i_target,
    input  logic         i_dir,
    output logic [W-1:0] o_next,
    output logic         o_reached
);
    logic [W:0] w_sum;
    logic [W:0] w_thr;
    logic       w_zero;

    // One extra bit on both sums so neither the carry nor the threshold can wrap.
    assign w_sum  = {1'b0, i_level}  + {1'b0, i_step};
    assign w_thr  = {1'b0, i_target} + {1'b0, i_step};
    assign w_zero = (i_step == '0);

    always_comb begin
        o_reached = 1'b0;
        o_next    = i_level;
        if (!i_dir) begin
            o_reached = w_zero || w_sum[W] || (w_sum[W-1:0] >= i_target);
            o_next    = o_reached ? i_target : w_sum[W-1:0];
        end else begin
            o_reached = w_zero || ({1'b0, i_level} <= w_thr);
            o_next    = o_reached ? i_target : (i_level - i_step);
        end
    end
endmodule

// File: rtl/adsr_envelope_core.sv
// Per-voice ADSR envelope: gate-edge driven phase FSM plus a tick-rate saturating level stepper.
module adsr_envelope_core
    import adsr_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    adsr_envelope_core_if.slave         bus
);
    phase_e       r_phase;
    logic [W-1:0] r_level;
    logic         r_active;
    logic         r_gate_q;

    logic         w_rise;
    logic         w_fall;
    logic [W-1:0] w_step;
    logic [W-1:0] w_target;
    logic         w_dir;
    logic [W-1:0] w_next;
    logic         w_reached;

    assign w_rise = bus.gate & ~r_gate_q;
    assign w_fall = ~bus.gate & r_gate_q;

    // Single stepper shared by all phases; SUSTAIN and IDLE use step 0 to snap onto their target.
    always_comb begin
        w_step   = '0;
        w_target = '0;
        w_dir    = 1'b1;
        case (r_phase)
            PH_ATTACK: begin
                w_step   = bus.attack_step;
                w_target = LEVEL_MAX;
                w_dir    = 1'b0;
            end
            PH_DECAY: begin
                w_step   = bus.decay_step;
                w_target = bus.sustain_level;
            end
            PH_SUSTAIN: w_target = bus.sustain_level;
            PH_RELEASE: w_step   = bus.release_step;
            default: ;
        endcase
    end

    env_sat_step u_step (
        .i_level   (r_level),
        .i_step    (w_step),
        .i_target  (w_target),
        .i_dir     (w_dir),
        .o_next    (w_next),
        .o_reached (w_reached)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase  <= PH_IDLE;
            r_level  <= '0;
            r_active <= 1'b0;
            r_gate_q <= 1'b0;
        end else begin
            r_gate_q <= bus.gate;
            // Gate edges take priority over tick; level is held on an edge cycle.
            if (w_rise) begin
                r_phase  <= PH_ATTACK;
                r_active <= 1'b1;
            end else if (w_fall && (r_phase == PH_ATTACK || r_phase == PH_DECAY ||
                                    r_phase == PH_SUSTAIN)) begin
                r_phase  <= PH_RELEASE;
            end else if (bus.tick) begin
                r_level <= w_next;
                case (r_phase)
                    PH_ATTACK:  if (w_reached) r_phase <= PH_DECAY;
                    PH_DECAY:   if (w_reached) r_phase <= PH_SUSTAIN;
                    PH_RELEASE: if (w_reached) begin
                        r_phase  <= PH_IDLE;
                        r_active <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.level  = r_level;
    assign bus.phase  = r_phase;
    assign bus.active = r_active;
endmodule

// File: tb/tb_adsr_envelope_core.sv
// Directed bench for adsr_envelope_core: full ADSR cycle, retrigger, zero steps, edge/tick, sustain tracking.
module tb_adsr_envelope_core;
    import adsr_pkg::*;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    adsr_envelope_core_if bus();

    adsr_envelope_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Drive gate/tick for one clk, then settle just after the rising edge.
    task automatic cyc(input logic g, input logic t);
        @(negedge clk);
        bus.gate = g;
        bus.tick = t;
        @(posedge clk);
        #1;
        bus.tick = 1'b0;
    endtask

    task automatic chk_st(input string tag, input logic [W-1:0] lvl, input logic [2:0] ph);
        chk({tag, ".level"}, 32'(bus.level), 32'(lvl));
        chk({tag, ".phase"}, 32'(bus.phase), 32'(ph));
        chk({tag, ".active"}, 32'(bus.active), 32'(ph != 3'd0));
    endtask

    task automatic set_steps(input logic [W-1:0] a, d, s, r);
        bus.attack_step   = a;
        bus.decay_step    = d;
        bus.sustain_level = s;
        bus.release_step  = r;
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.tick = 1'b0;
        bus.gate = 1'b0;
        set_steps(20'h40000, 20'h10000, 20'h80000, 20'h20000);
        repeat (2) @(posedge clk);
        #1;
        chk_st("rst", 20'h0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: async reset mid-attack
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        chk_st("t1.pre", 20'h40000, 3'd1);
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        bus.gate = 1'b0;
        #1;
        chk_st("t1.async", 20'h0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 2: full cycle
        cyc(1'b1, 1'b0);
        chk_st("t2.rise", 20'h0, 3'd1);
        cyc(1'b1, 1'b1); chk_st("t2.a1", 20'h40000, 3'd1);
        cyc(1'b1, 1'b1); chk_st("t2.a2", 20'h80000, 3'd1);
        cyc(1'b1, 1'b1); chk_st("t2.a3", 20'hC0000, 3'd1);
        cyc(1'b1, 1'b1); chk_st("t2.a4", 20'hFFFFF, 3'd2);
        for (int i = 1; i <= 7; i++) begin
            cyc(1'b1, 1'b1);
            chk_st($sformatf("t2.d%0d", i), 20'hFFFFF - 20'(i * 32'h10000), 3'd2);
        end
        cyc(1'b1, 1'b1); chk_st("t2.d8", 20'h80000, 3'd3);
        cyc(1'b1, 1'b1); chk_st("t2.s", 20'h80000, 3'd3);
        cyc(1'b0, 1'b0); chk_st("t2.fall", 20'h80000, 3'd4);
        cyc(1'b0, 1'b1); chk_st("t2.r1", 20'h60000, 3'd4);
        cyc(1'b0, 1'b1); chk_st("t2.r2", 20'h40000, 3'd4);
        cyc(1'b0, 1'b1); chk_st("t2.r3", 20'h20000, 3'd4);
        cyc(1'b0, 1'b1); chk_st("t2.r4", 20'h0, 3'd0);
        cyc(1'b0, 1'b1); chk_st("t2.idle", 20'h0, 3'd0);

        // 3: retrigger from mid-release
        cyc(1'b1, 1'b0);
        repeat (12) cyc(1'b1, 1'b1);
        chk_st("t3.sus", 20'h80000, 3'd3);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        chk_st("t3.rel", 20'h40000, 3'd4);
        cyc(1'b1, 1'b0); chk_st("t3.retrig", 20'h40000, 3'd1);
        cyc(1'b1, 1'b1); chk_st("t3.a1", 20'h80000, 3'd1);

        // 5: fall coincident with tick during DECAY
        cyc(1'b1, 1'b1); chk_st("t5.a2", 20'hC0000, 3'd1);
        cyc(1'b1, 1'b1); chk_st("t5.a3", 20'hFFFFF, 3'd2);
        cyc(1'b1, 1'b1); chk_st("t5.d1", 20'hEFFFF, 3'd2);
        cyc(1'b0, 1'b1); chk_st("t5.edge", 20'hEFFFF, 3'd4);
        cyc(1'b0, 1'b1); chk_st("t5.r1", 20'hCFFFF, 3'd4);
        for (int i = 0; i < 20 && bus.phase != 3'd0; i++) cyc(1'b0, 1'b1);
        chk_st("t5.done", 20'h0, 3'd0);

        // 4: zero steps jump straight to each target
        set_steps(20'h0, 20'h0, 20'h12345, 20'h0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1); chk_st("t4.a", 20'hFFFFF, 3'd2);
        cyc(1'b1, 1'b1); chk_st("t4.d", 20'h12345, 3'd3);
        cyc(1'b0, 1'b0); chk_st("t4.fall", 20'h12345, 3'd4);
        cyc(1'b0, 1'b1); chk_st("t4.r", 20'h0, 3'd0);

        // 6: sustain above level at decay entry, then sustain tracking
        set_steps(20'h40000, 20'h10000, 20'hFFFFF, 20'h0);
        cyc(1'b1, 1'b0);
        repeat (4) cyc(1'b1, 1'b1);
        chk_st("t6.a", 20'hFFFFF, 3'd2);
        cyc(1'b1, 1'b1); chk_st("t6.d", 20'hFFFFF, 3'd3);
        bus.sustain_level = 20'h30000;
        cyc(1'b1, 1'b0); chk_st("t6.notick", 20'hFFFFF, 3'd3);
        cyc(1'b1, 1'b1); chk_st("t6.track", 20'h30000, 3'd3);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1); chk_st("t6.r", 20'h0, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
